// File: rtl/light_display.sv
// light_display: display stage for one traffic-light direction.
// Converts the captured countdown to BCD with a sequential subtract-by-ten
// loop. It scans a 4-digit active-low 7-segment display and drives the lamp
// LEDs. The green lamp blinks while the last three seconds of GREEN run down.
module light_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] light,
    input  logic [4:0] lightTime,
    input  logic       feedback,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic [2:0] led
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] L_RED    = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_GREEN  = 2'b10;

    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic {IDLE, CONV} state_t;

    // Captured inputs
    logic [1:0]         light_q;
    logic [4:0]         lt_q;

    // BCD converter
    state_t             state_q;
    logic [4:0]         rem_q;
    logic [1:0]         tens_q;
    logic [4:0]         conv_src_q;
    logic [1:0]         disp_tens_q;
    logic [3:0]         disp_ones_q;

    // Scan and blink timing
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               flash_q, flash_d;

    // Registered outputs
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;
    logic               dp_q, dp_d;
    logic [2:0]         led_q, led_d;

    // Look-ahead of the displayed digits so a digit update and a scan
    // wrap on the same edge show the new value in the new slot.
    logic               disp_upd;
    logic [1:0]         tens_nx;
    logic [3:0]         ones_nx;
    logic               scan_wrap;
    logic               blink_wrap;

    function automatic logic [6:0] digit7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] glyph7(input logic [1:0] l);
        logic [6:0] s;
        case (l)
            L_GREEN:  s = 7'h42;
            L_YELLOW: s = 7'h11;
            L_RED:    s = 7'h2F;
            default:  s = 7'h3F;
        endcase
        return s;
    endfunction

    // Register the controller outputs; everything downstream uses these copies
    always_ff @(posedge clk) begin
        if (rst) begin
            light_q <= 2'b00;
            lt_q    <= 5'd0;
        end else begin
            light_q <= light;
            lt_q    <= lightTime;
        end
    end

    // BCD FSM: repeated subtract-by-ten, commits both digits together at the end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            conv_src_q  <= 5'd0;
            disp_tens_q <= 2'd0;
            disp_ones_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lt_q != conv_src_q) begin
                        rem_q      <= lt_q;
                        conv_src_q <= lt_q;
                        tens_q     <= 2'd0;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    if (rem_q >= 5'd10) begin
                        rem_q  <= rem_q - 5'd10;
                        tens_q <= tens_q + 2'd1;
                    end else begin
                        disp_tens_q <= tens_q;
                        disp_ones_q <= rem_q[3:0];
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Next-state for scan, blink and the registered display outputs
    always_comb begin
        disp_upd = (state_q == CONV) && (rem_q < 5'd10);
        tens_nx  = disp_upd ? tens_q     : disp_tens_q;
        ones_nx  = disp_upd ? rem_q[3:0] : disp_ones_q;

        scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        idx_d      = scan_wrap ? idx_q + 2'd1 : idx_q;

        blink_wrap  = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        flash_d     = flash_q;
        if (feedback) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
            flash_d     = 1'b1;
        end else if (blink_wrap) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
            flash_d     = 1'b0;
        end

        case (idx_d)
            2'd0:    seg_d = digit7(ones_nx);
            2'd1:    seg_d = (tens_nx == 2'd0) ? BLANK : digit7({2'b00, tens_nx});
            2'd2:    seg_d = BLANK;
            default: seg_d = glyph7(light_q);
        endcase
        an_d = ~(4'b0001 << idx_d);
        dp_d = ~(flash_d && (idx_d == 2'd3));

        led_d = 3'b000;
        case (light_q)
            L_RED:    led_d = 3'b100;
            L_YELLOW: led_d = 3'b010;
            L_GREEN:  led_d = {2'b00, ((lt_q >= 5'd1) && (lt_q <= 5'd3)) ? phase_q : 1'b1};
            default:  led_d = 3'b000;
        endcase
    end

    // Scan/blink counters and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            idx_q       <= 2'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            flash_q     <= 1'b0;
            seg_q       <= BLANK;
            an_q        <= 4'b1111;
            dp_q        <= 1'b1;
            led_q       <= 3'b000;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            flash_q     <= flash_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            dp_q        <= dp_d;
            led_q       <= led_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;
    assign led = led_q;

endmodule

// File: doc/light_display.md
# light_display

Downstream display stage for one traffic-light direction. It consumes the controller's `light`, `lightTime` and `feedback` outputs and drives one 4-digit multiplexed 7-segment display plus three lamp LEDs. The block converts the 5-bit countdown to BCD with a small sequential subtractor, scans the digits, and blinks the green lamp during the last 3 seconds of GREEN. It runs on the raw system clock, not the 1 s divided clock.

## Interface
- `SCAN_DIV`, default 50000: `clk` cycles per digit slot; must be ≥ 2.
- `BLINK_DIV`, default 12500000: `clk` cycles per blink half-period; must be ≥ 2.
- `clk` in 1: system clock; the only clock in the block.
- `rst` in 1: synchronous, active-high reset.
- `light` in 2: lamp code; 00 RED, 01 YELLOW, 10 GREEN, 11 UNDEFINED.
- `lightTime` in 5: remaining seconds, 0..31.
- `feedback` in 1: transition pulse from the controller; level-sampled on every `clk` edge.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `an` out 4: digit enables, active-low; `an[0]` is the rightmost digit.
- `dp` out 1: decimal point, active-low.
- `led` out 3: {R,Y,G}, active-high.

## Operation
- Capture:
  - `light_q` and `lt_q` register `light` and `lightTime` on every edge.
  - All logic below uses only the captured values.
- BCD FSM, state IDLE:
  - Condition: `lt_q != conv_src`.
  - Action: `rem<=lt_q`, `conv_src<=lt_q`, `tens<=0`, go to CONV.
- BCD FSM, state CONV:
  - If `rem>=10`: `rem<=rem-10`, `tens<=tens+1`.
  - Otherwise: `disp_tens<=tens`, `disp_ones<=rem`, go to IDLE.
- BCD widths: `rem` is 5 bits, `tens` is 2 bits (max 3).
- Input changes during CONV are not lost. On return to IDLE the mismatch is seen again and a new conversion starts.
- Digit content:
  - `an[0]`: `disp_ones`.
  - `an[1]`: `disp_tens`; blank (7'h7F) when 0.
  - `an[2]`: always blank.
  - `an[3]`: colour glyph. GREEN 7'h42, YELLOW 7'h11, RED 7'h2F, UNDEFINED 7'h3F.
- Digit encodings 0..9: 40,79,24,30,19,12,02,78,00,10 (hex).
- Scan:
  - `scan_cnt` counts 0..SCAN_DIV-1.
  - On wrap, `idx` increments mod 4.
  - `an` is the active-low one-hot of `idx`; `seg` is the content for `idx`. Both are registered.
- Lamps:
  - `led` is the one-hot of `light_q`; UNDEFINED gives 000.
  - Green bit = `phase` when `light_q==GREEN` and 1≤`lt_q`≤3; otherwise it is steady.
- Blink:
  - `blink_cnt` counts 0..BLINK_DIV-1; on wrap, `phase` toggles.
  - When `feedback`=1: `blink_cnt<=0`, `phase<=1`, `flash<=1`.
  - When `feedback`=0 and `blink_cnt` wraps: `flash<=0`.
- `dp` is low only while `flash`=1 and `idx==3`.

## Timing
- Reset values, applied while `rst`=1:
  - Outputs: `seg`=7'h7F, `an`=4'b1111, `dp`=1, `led`=000.
  - Internal: `light_q`=00, `lt_q`=0, `conv_src`=0, `disp_tens`=0, `disp_ones`=0, FSM IDLE, `scan_cnt`=0, `idx`=0, `blink_cnt`=0, `phase`=1, `flash`=0.
- First edge after `rst` falls: `an`=4'b1110, `seg`=7'h40 ("0").
- Conversion latency, with `lightTime` changing to v before edge E:
  - E captures v.
  - E+1 loads the FSM.
  - `disp_*` are valid after edge E+2+floor(v/10).
  - The value reaches `seg` when `idx` next selects that digit.
- Lamp latency: `led` follows `light` 2 edges after the input changes (capture edge plus output register).
- Precedence:
  - `rst` overrides everything. Reset mid-conversion returns to IDLE with digits 0.
  - `feedback` overrides a simultaneous blink wrap: `phase`=1, not toggled.
  - A scan wrap and a digit update on the same edge: the new `idx` shows the new digit value.
- Boundaries:
  - `lightTime`=0 shows blank/"0".
  - `lightTime`=31 shows "31" after 4 CONV cycles.
  - `lightTime` equal to `conv_src` never starts a conversion.

## Test plan
- Reset then release, SCAN_DIV=4 -> `an` cycles 1110,1101,1011,0111, each held 4 clk. Segs: 40, 7F, 7F, 2F (RED after reset).
- `light`=GREEN, `lightTime`=16 -> after ≤5 edges the slots show 79 (tens "1") and 02 (ones "6"); `an[3]` slot shows 42; `led`=001.
- `lightTime` steps 31→5 mid-CONV -> "31" is displayed first, then " 5" (tens blank, ones 12) with no corrupt intermediate value.
- GREEN, `lightTime`=3, BLINK_DIV=8 -> `led[0]` toggles every 8 clk; `lightTime`=4 gives steady 1.
- `feedback` pulse coincident with a blink wrap -> `phase`=1, `blink_cnt`=0. `dp`=0 only in the `idx`=3 slot, until the next wrap.
- `rst` asserted during CONV with `lightTime`=27 -> all outputs at reset values next edge. After release, "27" is reconverted.
